avr_exec_ctrl: RTL and testbench

//  Execution sequencer for the AVR core: generates the single-cycle core step enable that replaces
//  the free-running clock divider, and implements HALT/RUN/STEP commands from a debug host.

---
 rtl/avr_exec_ctrl_if.sv | 13 +
 rtl/avr_exec_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_avr_exec_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_exec_ctrl_if.sv
// Host command channel for avr_exec_ctrl: valid/ready handshake, opcode, operand and error pulse.
interface avr_exec_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_err;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, cmd_err);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready, cmd_err);
endinterface

// File: rtl/avr_exec_ctrl.sv
// AVR execution sequencer: step-enable divider, HALT/RUN/STEP debug control, ROM reload port.
// Breakpoint unit is built only when AVR_EXEC_BREAKPOINT_EN is defined.
module avr_exec_ctrl #(
  parameter int unsigned      DIV_W       = 26,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(26'h1FFFFFF),
  parameter int unsigned      AW          = 8,
  parameter int unsigned      DW          = 16
) (
  input  logic           clk50_i,
  input  logic           reset_i,
  avr_exec_ctrl_if.slave cmd,
  input  logic [AW-1:0]  core_ip_i,
  output logic           step_en_o,
  output logic           halted_o,
  output logic           rom_we_o,
  output logic [AW-1:0]  rom_addr_o,
  output logic [DW-1:0]  rom_wdata_o,
  output logic           bp_hit_o
);
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_HALT, OP_RUN, OP_STEP, OP_SET_DIV, OP_LOAD_ADDR, OP_WRITE, OP_SET_BP
  } op_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_reload_q, div_reload_d;
  logic [7:0]       step_left_q, step_left_d;
  logic             step_en_q, step_en_d, rom_we_q, rom_we_d, cmd_err_q, cmd_err_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [DW-1:0]    rom_wdata_q, rom_wdata_d;
  logic             accept, counting, expire, bp_stop;
  op_e              op;
`ifdef AVR_EXEC_BREAKPOINT_EN
  logic [AW-1:0]    bp_addr_q, bp_addr_d;
  logic             bp_valid_q, bp_valid_d, first_q, first_d, bp_hit_q, bp_hit_d;
`else
  logic [AW-1:0]    unused_core_ip;
  assign unused_core_ip = core_ip_i;
`endif

  assign op       = op_e'(cmd.cmd_op);
  assign accept   = cmd.cmd_valid && !rom_we_q;
  assign counting = (state_q == S_RUN) || (state_q == S_STEP && step_left_q != 8'd0);
  assign expire   = counting && (div_cnt_q == '0);
`ifdef AVR_EXEC_BREAKPOINT_EN
  // The first expiry after (re)entry is exempt so the core can leave the breakpoint address.
  assign bp_stop  = expire && bp_valid_q && !first_q && (core_ip_i == bp_addr_q);
`else
  assign bp_stop  = 1'b0;
`endif

  always_ff @(posedge clk50_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_HALT;
      div_cnt_q    <= '0;
      div_reload_q <= DIV_DEFAULT;
      step_left_q  <= '0;
      step_en_q    <= 1'b0;
      rom_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
`ifdef AVR_EXEC_BREAKPOINT_EN
      bp_addr_q    <= '0;
      bp_valid_q   <= 1'b0;
      first_q      <= 1'b0;
      bp_hit_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_reload_q <= div_reload_d;
      step_left_q  <= step_left_d;
      step_en_q    <= step_en_d;
      rom_we_q     <= rom_we_d;
      cmd_err_q    <= cmd_err_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
`ifdef AVR_EXEC_BREAKPOINT_EN
      bp_addr_q    <= bp_addr_d;
      bp_valid_q   <= bp_valid_d;
      first_q      <= first_d;
      bp_hit_q     <= bp_hit_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    div_reload_d = div_reload_q;
    step_left_d  = step_left_q;
    step_en_d    = 1'b0;
    rom_we_d     = 1'b0;
    cmd_err_d    = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
`ifdef AVR_EXEC_BREAKPOINT_EN
    bp_addr_d    = bp_addr_q;
    bp_valid_d   = bp_valid_q;
    first_d      = first_q;
    bp_hit_d     = bp_hit_q;
`endif

    if (rom_we_q) rom_addr_d = rom_addr_q + AW'(1);

    if (counting) begin
      if (!expire) begin
        div_cnt_d = div_cnt_q - DIV_W'(1);
      end else begin
        div_cnt_d = div_reload_q;
`ifdef AVR_EXEC_BREAKPOINT_EN
        first_d   = 1'b0;
        if (bp_stop) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
`endif
        if (!bp_stop) begin
          step_en_d = 1'b1;
          if (state_q == S_STEP) step_left_d = step_left_q - 8'd1;
        end
      end
    end else if (state_q == S_STEP) begin
      state_d = S_HALT;
    end

    if (accept) begin
      case (op)
        OP_HALT: begin
          // Overrides anything the divider scheduled this cycle, including a breakpoint stop.
          state_d   = S_HALT;
          step_en_d = 1'b0;
`ifdef AVR_EXEC_BREAKPOINT_EN
          bp_hit_d  = bp_hit_q;
`endif
        end
        OP_RUN, OP_STEP: begin
          if (state_q == S_HALT) begin
            state_d   = (op == OP_RUN) ? S_RUN : S_STEP;
            div_cnt_d = div_reload_q;
            if (op == OP_STEP)
              step_left_d = (cmd.cmd_data[7:0] == 8'd0) ? 8'd1 : cmd.cmd_data[7:0];
`ifdef AVR_EXEC_BREAKPOINT_EN
            first_d  = 1'b1;
            bp_hit_d = 1'b0;
`endif
          end
        end
        OP_SET_DIV: div_reload_d = DIV_W'(cmd.cmd_data);
        OP_LOAD_ADDR: begin
          if (state_q == S_HALT) rom_addr_d = cmd.cmd_data[AW-1:0];
          else                   cmd_err_d  = 1'b1;
        end
        OP_WRITE: begin
          if (state_q == S_HALT) begin
            rom_we_d    = 1'b1;
            rom_wdata_d = cmd.cmd_data;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_SET_BP: begin
`ifdef AVR_EXEC_BREAKPOINT_EN
          bp_addr_d  = cmd.cmd_data[AW-1:0];
          bp_valid_d = cmd.cmd_data[15];
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd.cmd_ready = !rom_we_q;
    cmd.cmd_err   = cmd_err_q;
    step_en_o     = step_en_q;
    halted_o      = (state_q == S_HALT);
    rom_we_o      = rom_we_q;
    rom_addr_o    = rom_addr_q;
    rom_wdata_o   = rom_wdata_q;
`ifdef AVR_EXEC_BREAKPOINT_EN
    bp_hit_o      = bp_hit_q;
`else
    bp_hit_o      = 1'b0;
`endif
  end
endmodule

// File: tb/tb_avr_exec_ctrl.sv
// Self-checking bench for avr_exec_ctrl: command table plus timed RUN/STEP/HALT/reset sequences.
module tb_avr_exec_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RUN = 3'd2, STEP = 3'd3,
                         SET_DIV = 3'd4, LOAD_ADDR = 3'd5, WRITE = 3'd6, SET_BP = 3'd7;

  logic          clk50 = 1'b0;
  logic          reset;
  logic [AW-1:0] core_ip;
  logic          step_en, halted, rom_we, bp_hit;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_wdata;

  avr_exec_ctrl_if #(.DW(DW)) cmd_if ();

  avr_exec_ctrl #(.DIV_W(26), .DIV_DEFAULT(26'h1FFFFFF), .AW(AW), .DW(DW)) dut (
    .clk50_i    (clk50),
    .reset_i    (reset),
    .cmd        (cmd_if),
    .core_ip_i  (core_ip),
    .step_en_o  (step_en),
    .halted_o   (halted),
    .rom_we_o   (rom_we),
    .rom_addr_o (rom_addr),
    .rom_wdata_o(rom_wdata),
    .bp_hit_o   (bp_hit)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  // Minimal core: ip advances once per step pulse.
  logic [7:0] ip_cnt = 8'd0;
  logic [7:0] ip_base = 8'd0;
  always @(posedge clk50) if (step_en === 1'b1) ip_cnt <= ip_cnt + 8'd1;
  assign core_ip = ip_base + ip_cnt;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event at cycle %0d, expected none", name, cyc);
  endfunction

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } rom_exp_t;

  int       pulse_q[$];
  int       err_q[$];
  rom_exp_t rom_q[$];

  always @(negedge clk50) begin
    rom_exp_t e;
    if (reset === 1'b0) begin
      if (step_en !== 1'b0) begin
        if (pulse_q.size() == 0) fail_evt("step_en_extra");
        else chk("step_en_cycle", cyc, pulse_q.pop_front());
      end
      if (rom_we !== 1'b0) begin
        if (rom_q.size() == 0) fail_evt("rom_we_extra");
        else begin
          e = rom_q.pop_front();
          chk("rom_we_cycle", cyc, e.cyc);
          chk("rom_addr", 32'(rom_addr), 32'(e.addr));
          chk("rom_wdata", 32'(rom_wdata), 32'(e.data));
          chk("cmd_ready_in_we", 32'(cmd_if.cmd_ready), 32'd0);
        end
      end
      if (cmd_if.cmd_err !== 1'b0) begin
        if (err_q.size() == 0) fail_evt("cmd_err_extra");
        else chk("cmd_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // Presents a command and returns its accept cycle before the accepting edge,
  // so expectations can be queued ahead of the DUT response.
  task automatic issue(input logic [2:0] op, input logic [15:0] data, output int acc);
    int unsigned g = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    while (cmd_if.cmd_ready !== 1'b1 && g < 8) begin
      @(negedge clk50);
      g++;
    end
    if (cmd_if.cmd_ready !== 1'b1) fail_evt("cmd_ready_timeout");
    acc = cyc + 1;
  endtask

  task automatic complete();
    @(negedge clk50);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_data  = '0;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] data, output int acc);
    issue(op, data, acc);
    complete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk50);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_pulses_missing"}, pulse_q.size(), 0);
    chk({tag, "_writes_missing"}, rom_q.size(), 0);
    chk({tag, "_errs_missing"}, err_q.size(), 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic        exp_we;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, h;
    vecs[0] = '{LOAD_ADDR, 16'h00FE, 1'b0, 8'h00};
    vecs[1] = '{WRITE,     16'hE0A5, 1'b1, 8'hFE};
    vecs[2] = '{WRITE,     16'hE1B6, 1'b1, 8'hFF};
    vecs[3] = '{WRITE,     16'h0000, 1'b1, 8'h00};
    vecs[4] = '{NOP,       16'hFFFF, 1'b0, 8'h00};
    vecs[5] = '{HALT,      16'h0000, 1'b0, 8'h00};
    vecs[6] = '{SET_BP,    16'h0000, 1'b0, 8'h00};
    vecs[7] = '{LOAD_ADDR, 16'h1234, 1'b0, 8'h00};
    vecs[8] = '{WRITE,     16'hBEEF, 1'b1, 8'h34};
    vecs[9] = '{SET_DIV,   16'h0003, 1'b0, 8'h00};

    reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_data  = '0;
    repeat (3) @(negedge clk50);
    chk("rst_step_en", 32'(step_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_cmd_err", 32'(cmd_if.cmd_err), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk50);

    // T1: divider 3 -> pulse 4 cycles after accept and every 4 after; HALT at N+16 suppresses that pulse
    send(SET_DIV, 16'd3, a);
    issue(RUN, 16'd0, n);
    pulse_q.push_back(n + 4);
    pulse_q.push_back(n + 8);
    pulse_q.push_back(n + 12);
    complete();
    chk("t1_running", 32'(halted), 32'd0);
    wait_until(n + 15);
    send(HALT, 16'd0, h);
    chk("t1_halted", 32'(halted), 32'd1);
    wait_until(h + 10);
    drain("t1");

    // T2: STEP 0 behaves as STEP 1; STEP 5 gives five pulses; halt follows the last pulse
    issue(STEP, 16'd0, n);
    pulse_q.push_back(n + 4);
    complete();
    wait_until(n + 4);
    chk("t2_step1_busy", 32'(halted), 32'd0);
    wait_until(n + 5);
    chk("t2_step1_halted", 32'(halted), 32'd1);
    issue(STEP, 16'h0105, n);
    for (int k = 1; k <= 5; k++) pulse_q.push_back(n + 4 * k);
    complete();
    wait_until(n + 20);
    chk("t2_step5_busy", 32'(halted), 32'd0);
    wait_until(n + 21);
    chk("t2_step5_halted", 32'(halted), 32'd1);
    wait_until(n + 30);
    drain("t2");

    // T3: table of halted-state commands, including address wrap and write back-pressure
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].data, a);
      if (vecs[i].exp_we) rom_q.push_back('{a, vecs[i].exp_addr, vecs[i].data});
      complete();
      chk("t3_halted", 32'(halted), 32'd1);
    end
    @(negedge clk50);
    chk("t3_addr_after", 32'(rom_addr), 32'h35);
    chk("t3_wdata_after", 32'(rom_wdata), 32'hBEEF);
    drain("t3");

    // T4: WRITE and LOAD_ADDR while running are rejected without disturbing the run
    issue(RUN, 16'd0, n);
    pulse_q.push_back(n + 4);
    pulse_q.push_back(n + 8);
    pulse_q.push_back(n + 12);
    complete();
    wait_until(n + 5);
    issue(WRITE, 16'h1234, a);
    err_q.push_back(a);
    complete();
    issue(LOAD_ADDR, 16'h0055, a);
    err_q.push_back(a);
    complete();
    chk("t4_running", 32'(halted), 32'd0);
    wait_until(n + 15);
    send(HALT, 16'd0, h);
    wait_until(h + 6);
    chk("t4_addr_kept", 32'(rom_addr), 32'h35);
    chk("t4_halted", 32'(halted), 32'd1);
    drain("t4");

    // T5: divider 0, STEP 3 halted after the first pulse; then reset mid-RUN
    send(SET_DIV, 16'd0, a);
    issue(STEP, 16'd3, n);
    pulse_q.push_back(n + 1);
    complete();
    wait_until(n + 1);
    send(HALT, 16'd0, h);
    chk("t5_halted", 32'(halted), 32'd1);
    wait_until(h + 6);
    drain("t5a");
    issue(RUN, 16'd0, n);
    pulse_q.push_back(n + 1);
    pulse_q.push_back(n + 2);
    pulse_q.push_back(n + 3);
    complete();
    wait_until(n + 3);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_step_en", 32'(step_en), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd1);
    chk("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk50);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk50);
    chk("t5_post_rst_step_en", 32'(step_en), 32'd0);
    drain("t5b");

`ifdef AVR_EXEC_BREAKPOINT_EN
    // T6: breakpoint at 0x10 stops without a pulse; the next RUN steps over it
    ip_base = 8'h0C - ip_cnt;
    send(SET_DIV, 16'd1, a);
    send(SET_BP, 16'h8010, a);
    issue(RUN, 16'd0, n);
    for (int k = 1; k <= 4; k++) pulse_q.push_back(n + 2 * k);
    complete();
    wait_until(n + 10);
    chk("t6_bp_halted", 32'(halted), 32'd1);
    chk("t6_bp_hit", 32'(bp_hit), 32'd1);
    chk("t6_bp_ip", 32'(core_ip), 32'h10);
    wait_until(n + 14);
    issue(RUN, 16'd0, n);
    pulse_q.push_back(n + 2);
    complete();
    wait_until(n + 1);
    chk("t6_bp_cleared", 32'(bp_hit), 32'd0);
    wait_until(n + 3);
    send(HALT, 16'd0, h);
    wait_until(h + 4);
    chk("t6_resume_ip", 32'(core_ip), 32'h11);
    chk("t6_resume_halted", 32'(halted), 32'd1);
    drain("t6");
`else
    chk("t6_bp_hit_tied", 32'(bp_hit), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
